// File: rtl/shift_arbiter.sv
// Shares one 8-bit left barrel shifter between two requesters, with round-robin grant,
// multi-pass shifts for amounts 0..15 and a sticky lost-bit flag. Define SHIFT_ARB_FIXED_PRIO_EN for fixed priority.
module shift_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_data,
   input  logic [3:0] req0_amt,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_data,
   input  logic [3:0] req1_amt,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic       res_id,
   output logic       res_lost
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t     state_q, state_d;
   logic [7:0] work_q, work_d;
   logic [3:0] amt_q, amt_d;
   logic       id_q, id_d;
   logic       lost_q, lost_d;
   logic [1:0] pass_q, pass_d;
   logic       last_grant_q, last_grant_d;
   logic [7:0] res_data_q, res_data_d;
   logic       res_id_q, res_id_d;
   logic       res_lost_q, res_lost_d;

   logic        grant0, grant1;
   logic [2:0]  shift_mag;
   logic [15:0] shift_wide;
   logic        last_pass;

   // Shared shifter: upper byte of the widened result holds the bits pushed past bit 7.
   always_comb begin
      shift_mag  = (pass_q == 2'd0) ? amt_q[2:0] : 3'd4;
      shift_wide = {8'h00, work_q} << shift_mag;
      last_pass  = (pass_q == (amt_q[3] ? 2'd2 : 2'd0));
   end

   always_comb begin
      state_d      = state_q;
      work_d       = work_q;
      amt_d        = amt_q;
      id_d         = id_q;
      lost_d       = lost_q;
      pass_d       = pass_q;
      last_grant_d = last_grant_q;
      res_data_d   = res_data_q;
      res_id_d     = res_id_q;
      res_lost_d   = res_lost_q;
      grant0       = 1'b0;
      grant1       = 1'b0;
      case (state_q)
         IDLE: begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            grant0 = req0_valid;
`else
            grant0 = req0_valid & (~req1_valid | last_grant_q);
`endif
            grant1 = req1_valid & ~grant0;
            if (grant0 | grant1) begin
               work_d       = grant0 ? req0_data : req1_data;
               amt_d        = grant0 ? req0_amt : req1_amt;
               id_d         = grant1;
               last_grant_d = grant1;
               lost_d       = 1'b0;
               pass_d       = 2'd0;
               state_d      = SHIFT;
            end
         end
         SHIFT: begin
            work_d = shift_wide[7:0];
            lost_d = lost_q | (|shift_wide[15:8]);
            pass_d = pass_q + 2'd1;
            if (last_pass) begin
               res_data_d = shift_wide[7:0];
               res_id_d   = id_q;
               res_lost_d = lost_d;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         work_q       <= 8'h00;
         amt_q        <= 4'd0;
         id_q         <= 1'b0;
         lost_q       <= 1'b0;
         pass_q       <= 2'd0;
         last_grant_q <= 1'b1;
         res_data_q   <= 8'h00;
         res_id_q     <= 1'b0;
         res_lost_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         work_q       <= work_d;
         amt_q        <= amt_d;
         id_q         <= id_d;
         lost_q       <= lost_d;
         pass_q       <= pass_d;
         last_grant_q <= last_grant_d;
         res_data_q   <= res_data_d;
         res_id_q     <= res_id_d;
         res_lost_q   <= res_lost_d;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign res_valid  = (state_q == DONE);
   assign res_data   = res_data_q;
   assign res_id     = res_id_q;
   assign res_lost   = res_lost_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vector table, randomized ops against a
// transaction-level model, plus arbitration, back-pressure and mid-operation reset sequences.
module tb_shift_arbiter;

   logic       clk;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_data, req1_data;
   logic [3:0] req0_amt, req1_amt;
   logic       res_valid, res_ready;
   logic [7:0] res_data;
   logic       res_id, res_lost;

   int  checks = 0;
   int  errors = 0;
   bit  m_last = 1'b1;

   typedef struct {
      bit         v0;
      bit         v1;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [3:0] a0;
      logic [3:0] a1;
      bit         eid;
      logic [7:0] edata;
      bit         elost;
      int         elat;
   } vec_t;

   vec_t vecs[10];

   shift_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_data  (req0_data),
      .req0_amt   (req0_amt),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_data  (req1_data),
      .req1_amt   (req1_amt),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_id     (res_id),
      .res_lost   (res_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Whole-operation model: the passes together shift by the full amount, so the result is
   // the low byte of a wide shift and lost is any bit above it.
   function automatic void refModel(input bit v0, input bit v1, input logic [7:0] d0,
                                    input logic [7:0] d1, input logic [3:0] a0,
                                    input logic [3:0] a1, input bit last, output bit id,
                                    output logic [7:0] data, output bit lost, output int lat);
      logic [31:0] wide;
      logic [3:0]  amt;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      id = v0 ? 1'b0 : 1'b1;
`else
      id = (v0 && (!v1 || last)) ? 1'b0 : 1'b1;
`endif
      amt  = id ? a1 : a0;
      wide = {24'h0, (id ? d1 : d0)} << amt;
      data = wide[7:0];
      lost = |wide[31:8];
      lat  = (amt >= 4'd8) ? 3 : 1;
   endfunction

   task automatic applyStimulus(input bit v0, input bit v1, input logic [7:0] d0,
                                input logic [7:0] d1, input logic [3:0] a0, input logic [3:0] a1);
      req0_valid = v0;
      req1_valid = v1;
      req0_data  = d0;
      req1_data  = d1;
      req0_amt   = a0;
      req1_amt   = a1;
   endtask

   task automatic doReset();
      @(negedge clk);
      applyStimulus(0, 0, 8'h00, 8'h00, 4'd0, 4'd0);
      res_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_last = 1'b1;
   endtask

   // One complete operation from an idle DUT: grant, latency, result, optional stall, handoff.
   task automatic runOp(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [3:0] a0, input logic [3:0] a1, input bit eid,
                        input logic [7:0] edata, input bit elost, input int elat,
                        input int stall);
      int lat;
      @(negedge clk);
      applyStimulus(v0, v1, d0, d1, a0, a1);
      #1;
      checkOutput("ready0_grant", {31'b0, req0_ready}, {31'b0, eid == 1'b0});
      checkOutput("ready1_grant", {31'b0, req1_ready}, {31'b0, eid == 1'b1});
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checkOutput("ready_after_accept", {30'b0, req0_ready, req1_ready}, 32'd0);
      lat = 0;
      while (!res_valid && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("latency", lat, elat);
      checkOutput("res_data", {24'b0, res_data}, {24'b0, edata});
      checkOutput("res_id", {31'b0, res_id}, {31'b0, eid});
      checkOutput("res_lost", {31'b0, res_lost}, {31'b0, elost});
      m_last = eid;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         req0_valid = 1'b1;
         req1_valid = 1'b1;
         #1;
         checkOutput("stall_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
         checkOutput("stall_valid", {31'b0, res_valid}, 32'd1);
         checkOutput("stall_data", {22'b0, res_data, res_id, res_lost},
                     {22'b0, edata, eid, elost});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      checkOutput("valid_after_handoff", {31'b0, res_valid}, 32'd0);
   endtask

   initial begin
      bit         rid, rlost;
      logic [7:0] rdata;
      int         rlat;
      bit         rv0, rv1;
      logic [7:0] rd0, rd1;
      logic [3:0] ra0, ra1;
      int         grants[$];
      int         expg;

      rst = 1'b0;
      res_ready = 1'b0;
      applyStimulus(0, 0, 8'h00, 8'h00, 4'd0, 4'd0);

      vecs[0] = '{1, 0, 8'h03, 8'h00, 4'd2, 4'd0, 0, 8'h0C, 0, 1};
      vecs[1] = '{0, 1, 8'h00, 8'hC1, 4'd0, 4'd3, 1, 8'h08, 1, 1};
      vecs[2] = '{1, 0, 8'h01, 8'h00, 4'd9, 4'd0, 0, 8'h00, 1, 3};
      vecs[3] = '{1, 0, 8'hA5, 8'h00, 4'd0, 4'd0, 0, 8'hA5, 0, 1};
      vecs[4] = '{0, 1, 8'h00, 8'hFF, 4'd0, 4'd7, 1, 8'h80, 1, 1};
      vecs[5] = '{0, 1, 8'h00, 8'h01, 4'd0, 4'd8, 1, 8'h00, 1, 3};
      vecs[6] = '{1, 0, 8'h00, 8'h00, 4'd15, 4'd0, 0, 8'h00, 0, 3};
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      vecs[7] = '{1, 1, 8'h11, 8'h0F, 4'd1, 4'd4, 0, 8'h22, 0, 1};
`else
      vecs[7] = '{1, 1, 8'h11, 8'h0F, 4'd1, 4'd4, 1, 8'hF0, 0, 1};
`endif
      vecs[8] = '{1, 1, 8'h80, 8'h55, 4'd1, 4'd2, 0, 8'h00, 1, 1};
      vecs[9] = '{0, 1, 8'h00, 8'h3C, 4'd0, 4'd10, 1, 8'h00, 1, 3};

      doReset();
      #1;
      checkOutput("reset_outputs", {20'b0, res_valid, res_data, res_id, res_lost, req0_ready, req1_ready},
                  32'd0);

      for (int i = 0; i < 10; i++)
         runOp(vecs[i].v0, vecs[i].v1, vecs[i].d0, vecs[i].d1, vecs[i].a0, vecs[i].a1,
               vecs[i].eid, vecs[i].edata, vecs[i].elost, vecs[i].elat, i % 3);

      // Result held under back-pressure for five cycles.
      runOp(1, 0, 8'h07, 8'h00, 4'd1, 4'd0, 0, 8'h0E, 0, 1, 5);

      for (int n = 0; n < 150; n++) begin
         rv0 = 1'($urandom_range(0, 1));
         rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
         rd0 = 8'($urandom);
         rd1 = 8'($urandom);
         ra0 = 4'($urandom);
         ra1 = 4'($urandom);
         refModel(rv0, rv1, rd0, rd1, ra0, ra1, m_last, rid, rdata, rlost, rlat);
         runOp(rv0, rv1, rd0, rd1, ra0, ra1, rid, rdata, rlost, rlat, int'($urandom_range(0, 3)));
      end

      // Both requesters held continuously after reset: grant order.
      doReset();
      @(negedge clk);
      applyStimulus(1, 1, 8'h01, 8'h02, 4'd1, 4'd1);
      res_ready = 1'b1;
      for (int c = 0; c < 40 && grants.size() < 4; c++) begin
         #1;
         checkOutput("one_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
         if (req0_ready) grants.push_back(0);
         else if (req1_ready) grants.push_back(1);
         if (grants.size() < 4) @(negedge clk);
      end
      checkOutput("grant_count", grants.size(), 4);
      for (int g = 0; g < grants.size(); g++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
         expg = 0;
`else
         expg = g % 2;
`endif
         checkOutput($sformatf("grant_seq%0d", g), grants[g], expg);
      end
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (6) @(negedge clk);
      res_ready = 1'b0;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      m_last = 1'b0;
`else
      m_last = 1'b1;
`endif

      // Reset in the middle of a multi-pass shift drops the operation.
      runOp(0, 1, 8'h00, 8'hFF, 4'd0, 4'd3, 1, 8'hF8, 1, 1, 0);
      @(negedge clk);
      applyStimulus(1, 0, 8'h01, 8'h00, 4'd9, 4'd0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midshift_reset", {20'b0, res_valid, res_data, res_id, res_lost, req0_ready, req1_ready},
                  32'd0);
      @(negedge clk);
      rst = 1'b0;
      m_last = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         checkOutput("no_result_after_reset", {31'b0, res_valid}, 32'd0);
      end
      runOp(1, 1, 8'h07, 8'h09, 4'd1, 4'd1, 0, 8'h0E, 0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
